// File: rtl/fetch_unit_if.sv
// Fetch-stage connection bundle: decode redirect, imem request/response and the instr queue head.
// Handshake: a transfer happens on a rising edge with valid && ready; payload holds while waiting.
interface fetch_unit_if #(
  parameter int QUEUE_DEPTH = 2
);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [31:0]   imem_req_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic [CW-1:0] dbg_count;
  logic [CW-1:0] dbg_outstanding;
  logic [CW-1:0] dbg_discard;

  modport fetch (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
           dbg_count, dbg_outstanding, dbg_discard
  );

  modport env (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data,
           instr_ready,
    input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
           dbg_count, dbg_outstanding, dbg_discard
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues credit-limited imem requests and queues {pc,instr}
// for decode; a decode redirect reloads the PC, flushes the queue and drops stale responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input logic         clock,
  input logic         reset,
  fetch_unit_if.fetch bus
);
  localparam int             CW       = $clog2(QUEUE_DEPTH + 1);
  localparam int             AW       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [CW:0]    DEPTH_C  = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [AW-1:0]  LAST_IDX = AW'(QUEUE_DEPTH - 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [31:0]   pc_mem_q   [QUEUE_DEPTH];
  logic [31:0]   data_mem_q [QUEUE_DEPTH];
  logic [31:0]   last_instr_q, last_pc_q;

  logic          credit_ok, req_valid, req_fire, push, pop;
  logic [31:0]   redirect_pc_al;
  logic [31:0]   instr_w, instr_pc_w;
  logic          redirect_lsb_unused;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign redirect_lsb_unused = ^bus.redirect_pc[1:0];

  always_comb begin
    // Credits count queue slots already promised, so every response is guaranteed a slot.
    credit_ok      = ({1'b0, outstanding_q} + {1'b0, count_q}) < DEPTH_C;
    req_valid      = !reset && !bus.redirect_valid && credit_ok;
    req_fire       = req_valid && bus.imem_req_ready;
    push           = bus.imem_rsp_valid && !bus.redirect_valid && (discard_q == '0);
    pop            = (count_q != '0) && bus.instr_ready;
    redirect_pc_al = {bus.redirect_pc[31:2], 2'b00};

    fetch_pc_d    = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    rsp_pc_d      = push ? rsp_pc_q + 32'd4 : rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
    discard_d     = (bus.imem_rsp_valid && (discard_q != '0)) ? discard_q - 1'b1 : discard_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    head_d        = pop ? ptr_inc(head_q) : head_q;
    tail_d        = push ? ptr_inc(tail_q) : tail_q;

    // Everything still in flight after this cycle belongs to the squashed path.
    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_pc_al;
      rsp_pc_d   = redirect_pc_al;
      discard_d  = outstanding_d;
      count_d    = '0;
      head_d     = '0;
      tail_d     = '0;
    end
  end

  always_comb begin
    instr_w    = last_instr_q;
    instr_pc_w = last_pc_q;
    if (reset) begin
      instr_w    = '0;
      instr_pc_w = '0;
    end else if (count_q != '0) begin
      instr_w    = data_mem_q[head_q];
      instr_pc_w = pc_mem_q[head_q];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      last_instr_q  <= '0;
      last_pc_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      last_instr_q  <= instr_w;
      last_pc_q     <= instr_pc_w;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      pc_mem_q[tail_q]   <= rsp_pc_q;
      data_mem_q[tail_q] <= bus.imem_rsp_data;
    end
  end

  assign bus.imem_req_valid  = req_valid;
  assign bus.imem_req_addr   = fetch_pc_q;
  assign bus.instr_valid     = !reset && (count_q != '0);
  assign bus.instr           = instr_w;
  assign bus.instr_pc        = instr_pc_w;
  assign bus.dbg_count       = count_q;
  assign bus.dbg_outstanding = outstanding_q;
  assign bus.dbg_discard     = discard_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: imem model with random in-order latency, and a program-order
// reference stream that every accepted request and every delivered instruction must follow.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  always #5 clock = ~clock;

  fetch_unit_if #(.QUEUE_DEPTH(DEPTH)) bus ();
  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clock (clock),
    .reset (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic        drv_reset = 1'b1;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_target = '0;
  logic        drv_req_ready = 1'b1;
  logic        drv_instr_ready = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          redir_mode = 0;
  logic [31:0] mode_target = '0;
  bit          redir_hit = 1'b0;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due = 0;
  int          pend_at_start = 0;
  logic [31:0] exp_pc  = RESET_PC;
  logic [31:0] exp_req = RESET_PC;
  logic [31:0] fired_addrs[$];
  logic [31:0] popped_pcs[$];
  int          deliveries = 0;
  int          first_accept_cyc = -1;
  int          first_valid_cyc  = -1;

  bit          prev_reset = 1'b0;
  bit          prev_redirect = 1'b0;
  bit          prev_req_stall = 1'b0;
  logic [31:0] prev_req_addr = '0;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_instr = '0;
  logic [31:0] prev_instr_pc = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A17;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #1;
  endtask

  // One clock cycle: drive at negedge, observe just before the next rising edge.
  task automatic tick();
    bit fired;
    bit popped;
    int due;
    @(negedge clock);
    rst                = drv_reset;
    bus.redirect_valid = drv_redirect;
    bus.redirect_pc    = drv_target;
    bus.imem_req_ready = drv_req_ready;
    bus.instr_ready    = drv_instr_ready;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom();
    pend_at_start      = pend_addr.size();
    if (!drv_reset && pend_addr.size() != 0 && pend_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data_of(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (!drv_reset && redir_mode == 1 && 32'(bus.dbg_outstanding) == 2) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = mode_target;
      redir_mode         = 0;
      redir_hit          = 1'b1;
    end
    if (!drv_reset && redir_mode == 2 && bus.imem_rsp_valid && bus.dbg_count != '0 &&
        drv_instr_ready) begin
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = mode_target;
      redir_mode         = 0;
      redir_hit          = 1'b1;
    end
    #2;
    if (rst) begin
      check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      check("rst_instr", bus.instr, 32'd0);
      check("rst_instr_pc", bus.instr_pc, 32'd0);
      pend_addr.delete();
      pend_due.delete();
      last_due = 0;
      exp_pc   = RESET_PC;
      exp_req  = RESET_PC;
      fired_addrs.delete();
      popped_pcs.delete();
      prev_reset     = 1'b1;
      prev_redirect  = 1'b0;
      prev_req_stall = 1'b0;
      prev_hold      = 1'b0;
    end else begin
      fired  = bus.imem_req_valid && bus.imem_req_ready;
      popped = bus.instr_valid && bus.instr_ready;
      if (prev_reset) begin
        check("post_rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("post_rst_instr", bus.instr, 32'd0);
        check("post_rst_instr_pc", bus.instr_pc, 32'd0);
        check("post_rst_outstanding", 32'(bus.dbg_outstanding), 32'd0);
      end
      check("inv_credit", 32'(int'(bus.dbg_outstanding) + int'(bus.dbg_count) <= DEPTH), 32'd1);
      check("inv_discard", 32'(bus.dbg_discard <= bus.dbg_outstanding), 32'd1);
      if (prev_redirect) begin
        check("redir_discard", 32'(bus.dbg_discard), 32'(pend_at_start));
        check("redir_flush", 32'(bus.instr_valid), 32'd0);
      end
      if (prev_req_stall && !bus.redirect_valid) begin
        check("req_hold_valid", 32'(bus.imem_req_valid), 32'd1);
        check("req_hold_addr", bus.imem_req_addr, prev_req_addr);
      end
      if (prev_hold) begin
        check("instr_hold_valid", 32'(bus.instr_valid), 32'd1);
        check("instr_hold_data", bus.instr, prev_instr);
        check("instr_hold_pc", bus.instr_pc, prev_instr_pc);
      end
      if (bus.instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (popped) begin
        check("pop_pc", bus.instr_pc, exp_pc);
        check("pop_data", bus.instr, data_of(exp_pc));
        popped_pcs.push_back(bus.instr_pc);
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (fired) begin
        check("req_addr", bus.imem_req_addr, exp_req);
        fired_addrs.push_back(bus.imem_req_addr);
        if (first_accept_cyc < 0) first_accept_cyc = cyc;
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(bus.imem_req_addr);
        pend_due.push_back(due);
        exp_req = exp_req + 32'd4;
      end
      if (bus.redirect_valid) begin
        check("redir_no_req", 32'(bus.imem_req_valid), 32'd0);
        exp_pc  = {bus.redirect_pc[31:2], 2'b00};
        exp_req = {bus.redirect_pc[31:2], 2'b00};
        fired_addrs.delete();
        popped_pcs.delete();
      end
      prev_reset     = 1'b0;
      prev_redirect  = bus.redirect_valid;
      prev_req_stall = bus.imem_req_valid && !bus.imem_req_ready;
      prev_req_addr  = bus.imem_req_addr;
      prev_hold      = bus.instr_valid && !bus.instr_ready && !bus.redirect_valid;
      prev_instr     = bus.instr;
      prev_instr_pc  = bus.instr_pc;
    end
    cyc++;
  endtask

  initial begin
    int base;
    int guard;

    // Reset held two cycles, then straight-line fetch with 1-cycle imem
    tick();
    tick();
    drv_reset = 1'b0;
    repeat (12) tick();
    check("t1_first_latency", 32'(first_valid_cyc - first_accept_cyc), 32'd2);
    check("t1_deliveries", 32'(deliveries >= 5), 32'd1);

    // Decode stalls: queue fills, requests stop, then delivery resumes in order
    drv_instr_ready = 1'b0;
    repeat (10) tick();
    check("t2_count_full", 32'(bus.dbg_count), 32'(DEPTH));
    check("t2_req_blocked", 32'(bus.imem_req_valid), 32'd0);
    base = deliveries;
    drv_instr_ready = 1'b1;
    repeat (10) tick();
    check("t2_resume", 32'(deliveries - base >= 4), 32'd1);

    // Redirect with two requests in flight
    lat_min = 4;
    lat_max = 4;
    mode_target = 32'h0000_0100;
    redir_hit = 1'b0;
    redir_mode = 1;
    guard = 0;
    while (!redir_hit && guard < 60) begin
      tick();
      guard++;
    end
    check("t3_reached", 32'(redir_hit), 32'd1);
    repeat (25) tick();
    check("t3_pops", 32'(popped_pcs.size() >= 2), 32'd1);
    check("t3_pc0", popped_pcs[0], 32'h0000_0100);
    check("t3_pc1", popped_pcs[1], 32'h0000_0104);

    // Redirect coinciding with a response and a pop
    lat_min = 1;
    lat_max = 2;
    mode_target = 32'h0000_0200;
    redir_hit = 1'b0;
    redir_mode = 2;
    guard = 0;
    while (!redir_hit && guard < 80) begin
      tick();
      guard++;
    end
    check("t4_reached", 32'(redir_hit), 32'd1);
    settle();
    check("t4_count", 32'(bus.dbg_count), 32'd0);
    check("t4_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("t4_discard", 32'(bus.dbg_discard), 32'(pend_addr.size()));
    repeat (10) tick();

    // Misaligned target at the top of the address space wraps to zero
    lat_min = 1;
    lat_max = 1;
    drv_redirect = 1'b1;
    drv_target = 32'hFFFF_FFFE;
    tick();
    drv_redirect = 1'b0;
    repeat (14) tick();
    check("t5_reqs", 32'(fired_addrs.size() >= 2), 32'd1);
    check("t5_addr0", fired_addrs[0], 32'hFFFF_FFFC);
    check("t5_addr1", fired_addrs[1], 32'h0000_0000);
    check("t5_pops", 32'(popped_pcs.size() >= 2), 32'd1);
    check("t5_pc0", popped_pcs[0], 32'hFFFF_FFFC);
    check("t5_pc1", popped_pcs[1], 32'h0000_0000);

    // Reset with a full queue, then refetch from RESET_PC
    lat_min = 3;
    lat_max = 3;
    drv_instr_ready = 1'b0;
    guard = 0;
    while (32'(bus.dbg_count) != DEPTH && guard < 40) begin
      tick();
      guard++;
    end
    check("t6_full", 32'(bus.dbg_count), 32'(DEPTH));
    drv_reset = 1'b1;
    tick();
    tick();
    drv_reset = 1'b0;
    drv_instr_ready = 1'b1;
    repeat (10) tick();
    check("t6_refetch_addr", fired_addrs[0], RESET_PC);
    check("t6_refetch_pc", popped_pcs[0], RESET_PC);

    // Random traffic: backpressure both sides, random latency and redirects
    lat_min = 1;
    lat_max = 4;
    base = deliveries;
    for (int i = 0; i < 800; i++) begin
      drv_req_ready   = ($urandom_range(0, 3) != 0);
      drv_instr_ready = ($urandom_range(0, 3) != 0);
      drv_redirect    = ($urandom_range(0, 19) == 0);
      drv_target      = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom();
      tick();
    end
    drv_redirect = 1'b0;
    drv_req_ready = 1'b1;
    drv_instr_ready = 1'b1;
    repeat (10) tick();
    check("rand_progress", 32'(deliveries - base >= 40), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
